// File: rtl/sbc_ctrl_pkg.sv
// sbc_ctrl_pkg -- shared types and helpers for the SBC early-termination
// sequencer (sbc_et_ctrl).
//   sbc_st_t    : sequencer state encoding
//   SBC_WIDTH   : default converter estimate width
//   SBC_MIN_CHK : default first checkpoint index minus one at which
//                 stability comparisons are allowed
//   clamp_prec  : maps a requested precision into the legal range 1..max
package sbc_ctrl_pkg;

    localparam int SBC_WIDTH   = 8;
    localparam int SBC_MIN_CHK = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CHECK,
        DONE
    } sbc_st_t;

    // A precision of 0 would mean a one-bit stream with no meaningful
    // checkpoint, so it is promoted to 1; anything above max_prec would
    // overflow the stream counter, so it is clamped.
    function automatic int unsigned clamp_prec(input int unsigned prec,
                                               input int unsigned max_prec);
        if (prec == 0)
            return 1;
        else if (prec > max_prec)
            return max_prec;
        else
            return prec;
    endfunction

endpackage

// File: rtl/sbc_abs_cmp.sv
// sbc_abs_cmp -- combinational stability test: le = (|a - b| <= tol).
//   a, b : unsigned WIDTH-bit estimates
//   tol  : unsigned WIDTH-bit tolerance
//   le   : 1 when the absolute difference is within tolerance
module sbc_abs_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] tol,
    output logic             le
);

    logic signed [WIDTH:0] diff;
    logic        [WIDTH:0] mag;

    // One extra bit makes the subtraction exact for any pair of unsigned
    // operands, so the magnitude never overflows.
    always_comb begin
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[WIDTH] ? unsigned'(-diff) : unsigned'(diff);
        le   = (mag <= {1'b0, tol});
    end

endmodule

// File: rtl/sbc_et_ctrl.sv
// sbc_et_ctrl -- sequencer for one stochastic-to-binary converter with
// progressive-precision early termination.
//
// A job (precision k_max, tolerance) is accepted on start_valid/start_ready.
// The converter is cleared for one cycle, then the bitstream runs; after
// 2^k bits (k = 0,1,2,...) the stream pauses for one CHECK cycle. The job
// ends when 2^k_max bits have been consumed or, beyond checkpoint MIN_CHK,
// when the estimate moved by no more than the tolerance since the previous
// checkpoint. The result is offered on res_valid/res_ready.
//
// Build option: SBC_ET_EN -- when defined the stability comparison is
// active; otherwise only full-length termination exists, start_tol is
// ignored and res_early stays 0 (checkpoint pauses kept, same latency).
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   start_valid/ready, start_prec, start_tol   job request
//   sbc_clr, src_en converter clear / advance-one-bit controls
//   sbc_bz          converter estimate (bits enabled before this cycle)
//   res_valid/ready, res_data, res_len, res_early   result
//   busy            high whenever not in IDLE
module sbc_et_ctrl
    import sbc_ctrl_pkg::*;
#(
    parameter  int WIDTH   = SBC_WIDTH,
    parameter  int MIN_CHK = SBC_MIN_CHK,
    localparam int PW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [PW-1:0]    start_prec,
    input  logic [WIDTH-1:0] start_tol,
    output logic             sbc_clr,
    output logic             src_en,
    input  logic [WIDTH-1:0] sbc_bz,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH:0]   res_len,
    output logic             res_early,
    output logic             busy
);

    sbc_st_t          state;
    logic [WIDTH:0]   cnt;
    logic [PW-1:0]    k;
    logic [PW-1:0]    kmax;
    logic [WIDTH-1:0] prev_bz;
    logic [WIDTH:0]   pow_k;
    logic [WIDTH:0]   pow_kmax;
    logic [WIDTH:0]   cnt_nxt;
    logic             chk_ok;
    logic             stop_early;

    assign pow_k    = (WIDTH+1)'(1) << k;
    assign pow_kmax = (WIDTH+1)'(1) << kmax;
    assign cnt_nxt  = cnt + (WIDTH+1)'(1);
    assign chk_ok   = int'(k) > MIN_CHK;

`ifdef SBC_ET_EN
    logic [WIDTH-1:0] tol_q;
    logic             stable;

    sbc_abs_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a   (sbc_bz),
        .b   (prev_bz),
        .tol (tol_q),
        .le  (stable)
    );

    assign stop_early = chk_ok && stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tol_q <= '0;
        else if (state == IDLE && start_valid)
            tol_q <= start_tol;
    end
`else
    // Comparator removed: tolerance and history have no consumer.
    logic unused_noet;
    assign unused_noet = ^{start_tol, prev_bz, chk_ok};
    assign stop_early  = 1'b0;
`endif

    // All handshake and converter controls decode from state only.
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign sbc_clr     = (state == IDLE) || (state == CLEAR);
    assign src_en      = (state == RUN);
    assign res_valid   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            k         <= '0;
            kmax      <= PW'(1);
            prev_bz   <= '0;
            res_data  <= '0;
            res_len   <= '0;
            res_early <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        kmax    <= PW'(clamp_prec(32'(start_prec), WIDTH));
                        cnt     <= '0;
                        k       <= '0;
                        prev_bz <= '0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: state <= RUN;
                RUN: begin
                    cnt <= cnt_nxt;
                    // Leave RUN after the bit that brings the count to 2^k.
                    if (cnt_nxt == pow_k)
                        state <= CHECK;
                end
                CHECK: begin
                    if (cnt == pow_kmax) begin
                        res_data  <= sbc_bz;
                        res_len   <= cnt;
                        res_early <= 1'b0;
                        state     <= DONE;
                    end else if (stop_early) begin
                        res_data  <= sbc_bz;
                        res_len   <= cnt;
                        res_early <= 1'b1;
                        state     <= DONE;
                    end else begin
                        prev_bz <= sbc_bz;
                        k       <= k + PW'(1);
                        state   <= RUN;
                    end
                end
                DONE: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
